// File: rtl/decode_out_buffer_if.sv
// Output beat stream of the decode buffer: 32-bit beats with last flag, ready/valid handshake.
// The master drives data/valid/last; the slave returns ready.
interface decode_out_buffer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/decode_out_buffer.sv
// Buffers 65-bit clear words from the decrypt stage and replays each as two 32-bit beats, low half first.
// First beat is valid one edge after the capturing edge; writes never stall, so a full FIFO drops and flags.
module decode_out_buffer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [64:0]         clr_data,
  input  logic                clr_data_valid,
  decode_out_buffer_if.master m_if,
  output logic                accept_ok,
  output logic [ADDR_W:0]     level,
  input  logic                ovf_clear,
  output logic                overflow,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [64:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  logic [64:0]         out_word_q, out_word_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                push, drop, pop;
  logic                fifo_nonempty;

  // The producer cannot be stalled: a full FIFO drops the word even if a pop frees a slot this cycle.
  assign push          = clr_data_valid && (level_q != LVL_FULL);
  assign drop          = clr_data_valid && (level_q == LVL_FULL);
  assign fifo_nonempty = (level_q != '0);

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    out_word_d    = out_word_q;
    frame_cnt_d   = frame_cnt_q;
    m_if.m_valid  = 1'b0;
    m_if.m_data   = '0;
    m_if.m_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          out_word_d = mem_q[rd_ptr_q];
          state_d    = LO;
        end
      end
      LO: begin
        m_if.m_valid = 1'b1;
        m_if.m_data  = out_word_q[31:0];
        if (m_if.m_ready) begin
          state_d = HI;
        end
      end
      HI: begin
        m_if.m_valid = 1'b1;
        m_if.m_data  = out_word_q[63:32];
        m_if.m_last  = out_word_q[64];
        if (m_if.m_ready) begin
          if (out_word_q[64]) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
          // Reload straight from HI so consecutive words stream without a bubble.
          if (fifo_nonempty) begin
            pop        = 1'b1;
            out_word_d = mem_q[rd_ptr_q];
            state_d    = LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  assign ovf_d = drop ? 1'b1 : (ovf_clear ? 1'b0 : ovf_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_word_q  <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      out_word_q  <= out_word_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Storage array carries no reset; occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= clr_data;
    end
  end

  assign accept_ok = (DEPTH - int'(level_q)) > PIPE_LAT;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/decode_out_buffer.md
Name: decode_out_buffer

Overview:
- Downstream consumer of the decrypt compute stage. Captures each 65-bit clear word {last, data[63:0]} from that stage's fire-and-forget valid output into a FIFO.
- Replays each word as two 32-bit beats on a ready/valid master stream, low half first.
- Exports an issue-permission signal so the request issuer never has more words in flight than the buffer can absorb.
- Reports a sticky overflow flag and a count of completed frames.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, at least 4.
- ADDR_W, 4: log2(DEPTH).
- PIPE_LAT, 2: number of words that may be in flight in the upstream compute pipeline.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clr_data  in  65  bit 64 = frame-last flag; [63:0] = clear data
- clr_data_valid  in  1  single-cycle qualifier for clr_data; no backpressure is possible
- m_data  out  32  output beat
- m_valid  out  1  beat valid
- m_ready  in  1  sink accepts the beat
- m_last  out  1  final beat of a frame
- accept_ok  out  1  issuer may launch one new request this cycle
- level  out  ADDR_W+1  FIFO occupancy; excludes the output register
- ovf_clear  in  1  clears the overflow flag
- overflow  out  1  sticky: a word was dropped
- frame_cnt  out  16  frames fully transferred

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - State = IDLE; m_valid = 0, m_last = 0, m_data = 0.
  - overflow = 0, frame_cnt = 0.
  - Asserting reset mid-operation discards all buffered and in-register data.
- Write side:
  - On clr_data_valid with level < DEPTH: store clr_data at wr_ptr, wr_ptr++ (wraps modulo DEPTH).
  - If level == DEPTH at that edge, the word is dropped and overflow is set. This holds even when a pop occurs in the same cycle.
- Overflow flag: ovf_clear clears it. When a set and a clear occur in the same cycle, set wins.
- Level: +1 on write, -1 on pop, unchanged when both happen in the same cycle.
- accept_ok = (DEPTH - level) > PIPE_LAT. Combinational from the registered level.
- Output FSM:
  - IDLE: m_valid = 0. If level > 0, pop the head into the 65-bit out_word register and go to LO.
  - LO: m_valid = 1, m_data = out_word[31:0], m_last = 0. On m_ready, go to HI.
  - HI: m_valid = 1, m_data = out_word[63:32], m_last = out_word[64]. On m_ready:
    - if level > 0, pop the next word and go to LO (back-to-back, no bubble);
    - otherwise go to IDLE.
  - A word popped in HI in the same cycle it was written is not visible; the FIFO is read from registered state only.
- Beat stability: while m_valid = 1 and m_ready = 0, m_data and m_last hold constant.
- Latency:
  - clr_data_valid sampled at edge t (FSM idle, FIFO empty): first beat has m_valid = 1 after edge t+1.
  - A word therefore occupies at most 1 + 2 cycles before its last beat, given m_ready = 1.
- frame_cnt: +1 on each accepted HI beat with m_last = 1. Wraps 0xFFFF -> 0x0000.
- m_ready while m_valid = 0 is ignored.
- Total storage = DEPTH words in the FIFO plus 1 in the output register.

Test Plan:
1. Single word:
   - Stimulus: m_ready = 1; write {1'b1, 64'hDEADBEEF_01234567}.
   - Response: m_valid rises one edge after the write edge. Beat 0x01234567 (last 0), then 0xDEADBEEF (last 1). frame_cnt = 1, then m_valid = 0.
2. Backpressure:
   - Stimulus: m_ready = 0; write 3 consecutive words A, B, C (bit 64 = 0).
   - Response: m_data holds A[31:0] steady; level = 2.
   - Stimulus: raise m_ready.
   - Response: 6 contiguous beats A.lo, A.hi, B.lo, B.hi, C.lo, C.hi with no idle cycle. frame_cnt unchanged.
3. Fill/overflow:
   - Stimulus: m_ready = 0; 18 writes.
   - Response:
     - accept_ok goes low once level reaches 14.
     - Word 1 sits in out_word; words 2-17 fill the FIFO (level = 16).
     - Word 18 is dropped and overflow = 1.
     - Draining yields exactly 34 beats, in order.
4. Clear race:
   - Stimulus: ovf_clear pulsed in the same cycle as a dropped write.
   - Response: overflow = 1.
   - Stimulus: ovf_clear alone the next cycle.
   - Response: overflow = 0.
5. Reset mid-frame:
   - Stimulus: assert reset while in HI with level = 5.
   - Response: the edge after reset gives m_valid = 0, level = 0, frame_cnt = 0, accept_ok = 1. A post-reset write emits only the new word.
6. Counter wrap:
   - Stimulus: preload frame_cnt to 0xFFFF via 65535 last-flagged words (or a force in sim), then send one more last word.
   - Response: frame_cnt = 0x0000.
